// File: rtl/led_seq_pkg.sv
// led_seq_pkg: register map, control bit positions and FSM
// encoding shared by the LED sequencer and its bench.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // word index = addr[5:2]; STEP[i] lives at index 8+i
    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_PRESCALE = 4'h1;
    localparam logic [3:0] REG_STATUS   = 4'h2;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_LOOP  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam int BTN_START = 0;
    localparam int BTN_PAUSE = 1;
    localparam int BTN_STOP  = 2;

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer, stability counter and
// rising-edge pulse on the accepted level.
module button_debounce #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic rise
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // accept a new level once it has differed for CYCLES clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CMAX) begin
                level <= sync[1];
                rise  <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: Wishbone-programmed LED pattern table stepped
// by a prescaled tick, with debounced start/pause/stop buttons.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_STEPS       = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    input  logic [2:0]  buttons,
    output logic [7:0]  leds,
    output logic [7:0]  led_enb,
    output logic        irq
);
    localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [SW-1:0] LAST = SW'(NUM_STEPS - 1);

    logic [2:0]    btn_ev;
    logic          enable, loop;
    logic [15:0]   prescale;
    logic [23:0]   tab [NUM_STEPS];
    state_t        state, state_d;
    logic [SW-1:0] step, step_d, sel;
    logic [15:0]   tcnt, tcnt_d, pcnt, pcnt_d, dur;
    logic          done, done_d, load, finish;
    logic [7:0]    leds_d;
    logic          wb_req, wb_wr, ctrl_wr, stat_wr, step_hit;
    logic [3:0]    idx;
    logic          en_nx, start, stop, pause, tick, step_end;
    logic [31:0]   rdata;
    logic          unused;

    assign unused = ^{i_wb_addr[31:6], i_wb_addr[1:0], i_wb_data[31:24]};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (buttons[g]),
            .rise    (btn_ev[g])
        );
    end

    assign idx      = i_wb_addr[5:2];
    assign sel      = idx[SW-1:0];
    assign wb_req   = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wb_wr    = wb_req & i_wb_we;
    assign ctrl_wr  = wb_wr & (idx == REG_CTRL);
    assign stat_wr  = wb_wr & (idx == REG_STATUS);
    assign step_hit = idx[3] & ({1'b0, idx[2:0]} < 4'(NUM_STEPS));

    assign en_nx = ctrl_wr ? i_wb_data[CTRL_EN] : enable;
    assign start = (ctrl_wr & i_wb_data[CTRL_START]) | btn_ev[BTN_START];
    assign stop  = (ctrl_wr & i_wb_data[CTRL_STOP]) | btn_ev[BTN_STOP] | ~en_nx;
    assign pause = btn_ev[BTN_PAUSE];

    // a zero duration still occupies one tick
    assign tick     = (state == ST_RUN) && (pcnt == prescale);
    assign step_end = tick && (tcnt >= ((dur == 16'd0) ? 16'd0 : dur - 16'd1));

    // register file writes land on the edge that raises ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= 1'b0;
            loop     <= 1'b0;
            prescale <= '0;
            for (int i = 0; i < NUM_STEPS; i++) tab[i] <= '0;
        end else if (wb_wr) begin
            if (ctrl_wr) begin
                enable <= i_wb_data[CTRL_EN];
                loop   <= i_wb_data[CTRL_LOOP];
            end
            if (idx == REG_PRESCALE) prescale <= i_wb_data[15:0];
            if (step_hit) tab[sel] <= i_wb_data[23:0];
        end
    end

    // read mux; pulse bits and unmapped words read as zero
    always_comb begin
        rdata = '0;
        case (idx)
            REG_CTRL:     rdata = {30'd0, loop, enable};
            REG_PRESCALE: rdata = {16'd0, prescale};
            REG_STATUS:   rdata = {26'd0, done, 3'(step), state};
            default:      if (step_hit) rdata = {8'd0, tab[sel]};
        endcase
    end

    // single-cycle ack with registered read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= wb_req;
            if (wb_req) o_wb_data <= rdata;
        end
    end

    // next state: stop beats start, start beats pause
    always_comb begin
        state_d = state;
        step_d  = step;
        tcnt_d  = tcnt;
        pcnt_d  = pcnt;
        load    = 1'b0;
        finish  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            step_d  = '0;
            tcnt_d  = '0;
            pcnt_d  = '0;
        end else begin
            unique case (state)
                ST_IDLE: if (start) begin
                    state_d = ST_RUN;
                    step_d  = '0;
                    tcnt_d  = '0;
                    pcnt_d  = '0;
                    load    = 1'b1;
                end
                ST_PAUSE: if (start) begin
                    state_d = ST_RUN;
                    pcnt_d  = '0;
                end
                ST_RUN: begin
                    if (pause && !start) begin
                        state_d = ST_PAUSE;
                    end else if (step_end) begin
                        pcnt_d = '0;
                        tcnt_d = '0;
                        if (step != LAST) begin
                            step_d = step + 1'b1;
                            load   = 1'b1;
                        end else if (loop) begin
                            step_d = '0;
                            load   = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            step_d  = '0;
                            finish  = 1'b1;
                        end
                    end else if (tick) begin
                        pcnt_d = '0;
                        tcnt_d = tcnt + 16'd1;
                    end else begin
                        pcnt_d = pcnt + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // next outputs: pattern latched only when a step is loaded
    always_comb begin
        leds_d = leds;
        if (state_d == ST_IDLE) leds_d = '0;
        else if (load)          leds_d = tab[step_d][7:0];
        done_d = finish | (done & ~stat_wr);
    end

    // sequencer state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            step    <= '0;
            tcnt    <= '0;
            pcnt    <= '0;
            dur     <= '0;
            done    <= 1'b0;
            leds    <= '0;
            irq     <= 1'b0;
            led_enb <= 8'hFF;
        end else begin
            state   <= state_d;
            step    <= step_d;
            tcnt    <= tcnt_d;
            pcnt    <= pcnt_d;
            done    <= done_d;
            leds    <= leds_d;
            irq     <= finish;
            led_enb <= en_nx ? 8'h00 : 8'hFF;
            if (load) dur <= tab[step_d][23:8];
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed and randomized checks of the LED
// sequencer against a pattern-timeline model.
module tb_led_sequencer;
    localparam int NS = 4;
    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [2:0]  buttons = '0;
    logic [7:0]  leds, led_enb;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  pat_m [NS];
    logic [15:0] dur_m [NS];
    logic [7:0]  exp_q [$];

    led_sequencer #(.NUM_STEPS(NS), .DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wb_cyc  (cyc),
        .i_wb_stb  (stb),
        .i_wb_we   (we),
        .i_wb_addr (adr),
        .i_wb_data (dat),
        .o_wb_ack  (ack),
        .o_wb_data (rdat),
        .buttons   (buttons),
        .leds      (leds),
        .led_enb   (led_enb),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] r);
        bit got = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; r = '0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                got = 1'b1;
                r   = rdat;
            end
        end
        check("wb_ack", 32'(got), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb_access(1'b1, a, d, r);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
        wb_access(1'b0, a, 32'd0, r);
    endtask

    // timeline model: each step shows its pattern for
    // max(duration,1)*(prescale+1) cycles
    task automatic run_seq(input bit lp, input int p);
        logic [31:0] r;
        int n;
        wb_write(32'h00, 32'h0);
        wb_write(32'h08, 32'h0);
        for (int i = 0; i < NS; i++)
            wb_write(32'h20 + 32'(4 * i), {8'd0, dur_m[i], pat_m[i]});
        wb_write(32'h04, 32'(p));
        wb_write(32'h00, {30'd0, lp, 1'b1});
        exp_q.delete();
        for (int rnd = 0; rnd < (lp ? 2 : 1); rnd++)
            for (int i = 0; i < NS; i++) begin
                n = ((dur_m[i] == 0) ? 1 : int'(dur_m[i])) * (p + 1);
                for (int k = 0; k < n; k++) exp_q.push_back(pat_m[i]);
            end
        wb_write(32'h00, {28'd0, 2'b01, lp, 1'b1});
        check("led_enb_on", 32'(led_enb), 32'h00);
        for (int t = 0; t < exp_q.size(); t++) begin
            if (t > 0) cycles(1);
            check("leds_seq", 32'(leds), 32'(exp_q[t]));
            check("irq_quiet", 32'(irq), 32'd0);
        end
        if (!lp) begin
            cycles(1);
            check("leds_end", 32'(leds), 32'h0);
            check("irq_pulse", 32'(irq), 32'd1);
            cycles(1);
            check("irq_single", 32'(irq), 32'd0);
            wb_read(32'h08, r);
            check("status_done", r, 32'h20);
            wb_write(32'h08, 32'h0);
            wb_read(32'h08, r);
            check("status_clr", r, 32'h0);
        end
    endtask

    task automatic press(input int b, input int n);
        buttons[b] = 1'b1;
        cycles(n);
        buttons[b] = 1'b0;
    endtask

    initial begin
        logic [31:0] r;

        cycles(3);
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_enb", 32'(led_enb), 32'hFF);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_data", rdat, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(2);

        // back-to-back reads with cyc/stb held
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h08;
        cycles(1);
        check("b2b_ack0", 32'(ack), 32'd1);
        check("b2b_status", rdat, 32'h0);
        adr = 32'h44;
        cycles(1);
        check("b2b_gap", 32'(ack), 32'd0);
        cycles(1);
        check("b2b_ack1", 32'(ack), 32'd1);
        check("b2b_0x44", rdat, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        cycles(1);
        check("b2b_drop", 32'(ack), 32'd0);

        // 0x01 for 2 cycles, 0x02 for 3, looped then one-shot
        for (int i = 0; i < NS; i++) begin
            pat_m[i] = (i % 2 == 0) ? 8'h01 : 8'h02;
            dur_m[i] = (i % 2 == 0) ? 16'd2 : 16'd3;
        end
        run_seq(1'b1, 0);
        run_seq(1'b0, 0);

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < NS; i++) begin
                pat_m[i] = 8'($urandom);
                dur_m[i] = 16'($urandom_range(0, 3));
            end
            run_seq(1'($urandom), $urandom_range(0, 2));
        end

        // simultaneous start and stop stays idle
        wb_write(32'h00, 32'h0);
        wb_write(32'h00, 32'hF);
        cycles(1);
        check("ss_leds", 32'(leds), 32'h0);
        wb_read(32'h08, r);
        check("ss_state", {30'd0, r[1:0]}, 32'd0);
        wb_read(32'h00, r);
        check("ctrl_rb", r, 32'h3);

        // pause, glitch, resume through the buttons
        wb_write(32'h08, 32'h0);
        wb_write(32'h20, {8'd0, 16'd1000, 8'hA5});
        wb_write(32'h04, 32'h0);
        wb_write(32'h00, 32'h7);
        check("pz_run", 32'(leds), 32'hA5);
        press(1, DB + 3);
        cycles(3);
        wb_read(32'h08, r);
        check("pz_state", r, 32'h2);
        check("pz_leds", 32'(leds), 32'hA5);
        cycles(DB + 5);
        press(0, 10);
        cycles(DB + 5);
        wb_read(32'h08, r);
        check("glitch_state", r, 32'h2);
        check("glitch_leds", 32'(leds), 32'hA5);
        press(0, DB + 3);
        cycles(3);
        wb_read(32'h08, r);
        check("resume_state", r, 32'h1);
        check("resume_leds", 32'(leds), 32'hA5);
        cycles(DB + 5);

        // stop button
        press(2, DB + 3);
        cycles(3);
        wb_read(32'h08, r);
        check("stopbtn_state", r, 32'h0);
        check("stopbtn_leds", 32'(leds), 32'h0);
        cycles(DB + 5);

        // clearing enable forces idle and tristates the pads
        wb_write(32'h00, 32'h7);
        check("en_run", 32'(leds), 32'hA5);
        wb_write(32'h00, 32'h2);
        check("dis_leds", 32'(leds), 32'h0);
        check("dis_enb", 32'(led_enb), 32'hFF);
        wb_read(32'h08, r);
        check("dis_state", r, 32'h0);

        // asynchronous reset mid-run
        wb_write(32'h00, 32'h7);
        cycles(3);
        check("pre_rst_leds", 32'(leds), 32'hA5);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_leds", 32'(leds), 32'h0);
        check("arst_enb", 32'(led_enb), 32'hFF);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(1);
        wb_read(32'h20, r);
        check("arst_step0", r, 32'h0);
        wb_read(32'h00, r);
        check("arst_ctrl", r, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
